// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: elastic add/sub split into STAGES carry-chained chunks,
// one register stage per chunk, with valid/ready flow control and flush.
module pipelined_add_sub #(
    parameter int BITWIDTH = 64,
    parameter int STAGES   = 4
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                flush,
    input  logic                inValid,
    output logic                inReady,
    input  logic [BITWIDTH-1:0] in1,
    input  logic [BITWIDTH-1:0] in2,
    input  logic                cIn,
    input  logic                sub,
    output logic                outValid,
    input  logic                outReady,
    output logic [BITWIDTH-1:0] sum,
    output logic                cOut,
    output logic                overflow,
    output logic                zero
);

    localparam int CHUNK = BITWIDTH / STAGES;

    generate
        if (STAGES < 1 || (BITWIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("BITWIDTH must be divisible by STAGES (STAGES >= 1)");
        end
    endgenerate

    logic [STAGES-1:0][BITWIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0][BITWIDTH-1:0] a_d, b_d, s_d;
    logic [STAGES-1:0]               c_q, z_q, v_q;
    logic [STAGES-1:0]               c_d, z_d, v_d;
    logic [STAGES-1:0]               ci, zi, ld;
    logic [CHUNK:0]                  part;
    logic                            ov_q, ov_d;
    logic                            ready_en;
    logic                            unused_skew;

    // A stage loads when it or any stage downstream of it can move.
    always_comb begin
        logic acc;
        acc = outReady;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc   = acc || !v_q[k];
            ld[k] = acc;
        end
    end

    assign inReady = ready_en && ld[0];

    always_comb begin
        a_d[0] = in1;
        b_d[0] = sub ? ~in2 : in2;
        s_d[0] = '0;
        ci[0]  = sub | cIn;
        zi[0]  = 1'b1;
        v_d[0] = inValid && inReady;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            ci[k]  = c_q[k-1];
            zi[k]  = z_q[k-1];
            v_d[k] = v_q[k-1];
        end
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, a_d[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_d[k][k*CHUNK +: CHUNK]}
                 + (CHUNK+1)'(ci[k]);
            s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            c_d[k] = part[CHUNK];
            z_d[k] = zi[k] && (part[CHUNK-1:0] == '0);
        end
        ov_d = (a_d[STAGES-1][BITWIDTH-1] == b_d[STAGES-1][BITWIDTH-1])
            && (s_d[STAGES-1][BITWIDTH-1] != a_d[STAGES-1][BITWIDTH-1]);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            z_q      <= '0;
            v_q      <= '0;
            ov_q     <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                    z_q[k] <= z_d[k];
                end
                if (flush)
                    v_q[k] <= 1'b0;
                else if (ld[k])
                    v_q[k] <= v_d[k];
            end
            if (ld[STAGES-1])
                ov_q <= ov_d;
        end
    end

    // Consumed low chunks of the skewed operands are dead bits.
    assign unused_skew = ^{a_q, b_q};

    assign sum      = s_q[STAGES-1];
    assign cOut     = c_q[STAGES-1];
    assign zero     = z_q[STAGES-1];
    assign overflow = ov_q;
    assign outValid = v_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed and swept checks of the elastic add/sub
// pipe at 64/4 and 8/2 configurations.
module tb_pipelined_add_sub;

    logic        clk = 1'b0;
    logic        rstN, flush, cIn, sub, outReady;
    logic [63:0] in1, in2;
    logic        w_in_valid, w_in_ready, w_out_valid;
    logic [63:0] w_sum;
    logic        w_cout, w_ovf, w_zero;
    logic        n_in_valid, n_in_ready, n_out_valid;
    logic [7:0]  n_sum;
    logic        n_cout, n_ovf, n_zero;

    always #5 clk = ~clk;

    pipelined_add_sub #(.BITWIDTH(64), .STAGES(4)) dut (
        .clk(clk), .rstN(rstN), .flush(flush),
        .inValid(w_in_valid), .inReady(w_in_ready),
        .in1(in1), .in2(in2), .cIn(cIn), .sub(sub),
        .outValid(w_out_valid), .outReady(outReady),
        .sum(w_sum), .cOut(w_cout), .overflow(w_ovf), .zero(w_zero)
    );

    pipelined_add_sub #(.BITWIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rstN(rstN), .flush(flush),
        .inValid(n_in_valid), .inReady(n_in_ready),
        .in1(in1[7:0]), .in2(in2[7:0]), .cIn(cIn), .sub(sub),
        .outValid(n_out_valid), .outReady(outReady),
        .sum(n_sum), .cOut(n_cout), .overflow(n_ovf), .zero(n_zero)
    );

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        logic        s;
    } op_t;

    typedef struct packed {
        logic [63:0] sum;
        logic        c;
        logic        ov;
        logic        z;
    } res_t;

    op_t  send_q[$];
    res_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_acc, n_ret, first_ret, last_ret;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input op_t o, input bit narrow);
        res_t        r;
        logic [63:0] bb;
        logic [64:0] t;
        logic [8:0]  t8;
        bb = o.s ? ~o.b : o.b;
        if (narrow) begin
            t8   = {1'b0, o.a[7:0]} + {1'b0, bb[7:0]} + 9'(o.s | o.c);
            r.sum = {56'd0, t8[7:0]};
            r.c  = t8[8];
            r.ov = (o.a[7] == bb[7]) && (t8[7] != o.a[7]);
            r.z  = (t8[7:0] == 8'd0);
        end else begin
            t    = {1'b0, o.a} + {1'b0, bb} + 65'(o.s | o.c);
            r.sum = t[63:0];
            r.c  = t[64];
            r.ov = (o.a[63] == bb[63]) && (t[63] != o.a[63]);
            r.z  = (t[63:0] == 64'd0);
        end
        return r;
    endfunction

    task automatic stream(input bit narrow, input int rdy_pct,
                          input int max_cyc, input bit use_model);
        res_t g, e;
        op_t  o;
        logic ov_l, ir_l;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (send_q.size() == 0 && exp_q.size() == 0)
                break;
            @(negedge clk);
            outReady = ($urandom_range(99) < rdy_pct);
            w_in_valid = 1'b0;
            n_in_valid = 1'b0;
            if (send_q.size() > 0) begin
                o   = send_q[0];
                in1 = o.a;
                in2 = o.b;
                cIn = o.c;
                sub = o.s;
                if (narrow) n_in_valid = 1'b1;
                else        w_in_valid = 1'b1;
            end
            #1;
            if (narrow) begin
                g    = res_t'{{56'd0, n_sum}, n_cout, n_ovf, n_zero};
                ov_l = n_out_valid;
                ir_l = n_in_valid && n_in_ready;
            end else begin
                g    = res_t'{w_sum, w_cout, w_ovf, w_zero};
                ov_l = w_out_valid;
                ir_l = w_in_valid && w_in_ready;
            end
            if (ov_l && outReady) begin
                if (exp_q.size() == 0) begin
                    chk("extra_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", g.sum, e.sum);
                    chk("flags", {61'd0, g.c, g.ov, g.z},
                        {61'd0, e.c, e.ov, e.z});
                    n_ret++;
                    if (first_ret < 0) first_ret = cyc;
                    last_ret = cyc;
                end
            end
            if (ir_l) begin
                o = send_q.pop_front();
                if (use_model) exp_q.push_back(model(o, narrow));
                n_acc++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        w_in_valid = 1'b0;
        n_in_valid = 1'b0;
        outReady   = 1'b0;
    endtask

    task automatic directed(input logic [63:0] a, input logic [63:0] b,
                            input logic c, input logic s,
                            input logic [63:0] es, input logic ec,
                            input logic eov, input logic ez);
        send_q.push_back(op_t'{a, b, c, s});
        exp_q.push_back(res_t'{es, ec, eov, ez});
        first_ret = -1;
        stream(1'b0, 100, 20, 1'b0);
        chk("latency", 64'(first_ret), 64'd4);
        chk("drained", 64'(send_q.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        op_t  o;
        rstN = 1'b0;
        flush = 1'b0;
        cIn = 1'b0;
        sub = 1'b0;
        outReady = 1'b0;
        in1 = '0;
        in2 = '0;
        w_in_valid = 1'b0;
        n_in_valid = 1'b0;
        n_acc = 0;
        n_ret = 0;
        first_ret = -1;
        last_ret = -1;

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(w_out_valid), 64'd0);
        chk("rst_sum", w_sum, 64'd0);
        chk("rst_flags", {61'd0, w_cout, w_ovf, w_zero}, 64'd0);
        chk("rst_valid8", 64'(n_out_valid), 64'd0);
        rstN = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(w_in_ready), 64'd1);

        directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'd0, 1'b1, 1'b0, 1'b1);
        directed(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed(64'd5, 64'd7, 1'b0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
        directed(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        directed(64'd10, 64'd10, 1'b1, 1'b1,
                 64'd0, 1'b1, 1'b0, 1'b1);

        // back-to-back random stream
        for (int i = 0; i < 100; i++) begin
            o.a = {$urandom, $urandom};
            o.b = {$urandom, $urandom};
            o.c = 1'($urandom_range(1));
            o.s = 1'($urandom_range(1));
            send_q.push_back(o);
        end
        n_ret = 0;
        first_ret = -1;
        stream(1'b0, 100, 300, 1'b1);
        chk("b2b_count", 64'(n_ret), 64'd100);
        chk("b2b_first", 64'(first_ret), 64'd4);
        chk("b2b_last", 64'(last_ret), 64'd103);

        // backpressure: six operands, consumer stalled
        for (int i = 0; i < 6; i++)
            send_q.push_back(op_t'{64'(i * 3 + 1), 64'(i), 1'b0, 1'b0});
        n_acc = 0;
        stream(1'b0, 0, 10, 1'b1);
        #1;
        chk("bp_accepts", 64'(n_acc), 64'd4);
        chk("bp_ready", 64'(w_in_ready), 64'd0);
        chk("bp_hold_valid", 64'(w_out_valid), 64'd1);
        chk("bp_hold_sum", w_sum, 64'd1);
        n_ret = 0;
        stream(1'b0, 100, 40, 1'b1);
        chk("bp_results", 64'(n_ret), 64'd6);
        chk("bp_drained", 64'(send_q.size() + exp_q.size()), 64'd0);
        outReady = 1'b1;
        #1;
        chk("bp_idle", 64'(w_out_valid), 64'd0);

        // flush with three in flight plus one offered in the flush cycle
        for (int i = 0; i < 3; i++)
            send_q.push_back(op_t'{64'(i + 100), 64'd1, 1'b0, 1'b0});
        stream(1'b0, 0, 3, 1'b1);
        flush = 1'b1;
        outReady = 1'b1;
        in1 = 64'd999;
        in2 = 64'd1;
        cIn = 1'b0;
        sub = 1'b0;
        w_in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        w_in_valid = 1'b0;
        exp_q.delete();
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | int'(w_out_valid);
        end
        chk("flush_no_out", 64'(seen), 64'd0);
        directed(64'h1234, 64'h1111, 1'b0, 1'b0,
                 64'h2345, 1'b0, 1'b0, 1'b0);

        // asynchronous reset while results are held
        for (int i = 0; i < 5; i++)
            send_q.push_back(op_t'{64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                                   1'b0, 1'b0});
        stream(1'b0, 0, 8, 1'b1);
        #1;
        chk("pre_rst_sum", w_sum, 64'd1);
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_valid", 64'(w_out_valid), 64'd0);
        chk("arst_sum", w_sum, 64'd0);
        chk("arst_flags", {61'd0, w_cout, w_ovf, w_zero}, 64'd0);
        send_q.delete();
        exp_q.delete();
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // 8-bit / 2-stage sweep with random backpressure
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b += 17)
                for (int c = 0; c < 2; c++)
                    for (int s = 0; s < 2; s++)
                        send_q.push_back(op_t'{64'(a), 64'(b),
                                               1'(c), 1'(s)});
        n_ret = 0;
        stream(1'b1, 70, 40000, 1'b1);
        chk("sweep_count", 64'(n_ret), 64'd16384);
        chk("sweep_drained", 64'(send_q.size() + exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
